// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its CLA slice.

package nibble_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_cla.sv
// Purely combinational 4-bit carry-lookahead adder slice.

module nibble_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened from g/p/ci so no carry ripples through the slice.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                (p[3] & p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder sequencing one 4-bit CLA slice, one nibble per clock, LSB first.
// Define ADDSUB_EN to add the sub port and A - B support.

module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CntW    = $clog2(NIBBLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0]    b_load;
  logic                carry_load;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

`ifdef ADDSUB_EN
  // Subtraction is A + ~B + 1; cin is ignored in that mode.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub | cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  nibble_cla u_cla (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Operands shift right so the active nibble is always in the low bits.
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        sum_d[cnt_q*NIBBLE_W +: NIBBLE_W] = slice_s;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          cout_d  = slice_co;
          ovf_d   = (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) &&
                    (slice_s[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16), directed cases plus random vs model.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef ADDSUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADDSUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as numbers.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                       input logic ms, output logic [15:0] s, output logic co,
                       output logic ov);
    int full;
    int sr;
    if (ms) begin
      full = int'(ma) - int'(mb);
      co   = (ma >= mb);
      sr   = int'($signed(ma)) - int'($signed(mb));
    end else begin
      full = int'(ma) + int'(mb) + int'(mc);
      co   = (full > 65535);
      sr   = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    end
    s  = 16'(full);
    ov = (sr > 32767) || (sr < -32768);
  endtask

  // Issue one start and wait (bounded) for done; lat counts edges from the accept edge.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                       output int lat, output int bcnt);
    @(negedge clk);
    a     = ta;
    b     = tbv;
    cin   = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
  endtask

  initial begin
    int lat;
    int bcnt;
    int dones;
    logic [15:0] ra, rb, es;
    logic        rc, rs, ec, eo;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef ADDSUB_EN
    sub   = 1'b0;
`endif
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add and latency
    do_op(16'h1234, 16'h4321, 1'b0, lat, bcnt);
    check("basic_sum", sum, 16'h5555);
    check("basic_cout", cout, 0);
    check("basic_ovf", ovf, 0);
    check("basic_latency", lat, 4);
    check("basic_busy_cycles", bcnt, 4);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("sum_held", sum, 16'h5555);

    // Full carry propagation
    do_op(16'hFFFF, 16'h0001, 1'b0, lat, bcnt);
    check("carry_sum", sum, 16'h0000);
    check("carry_cout", cout, 1);
    check("carry_ovf", ovf, 0);

    // Signed overflow
    do_op(16'h7FFF, 16'h0001, 1'b0, lat, bcnt);
    check("ovf_sum", sum, 16'h8000);
    check("ovf_cout", cout, 0);
    check("ovf_ovf", ovf, 1);

    // Carry-in
    do_op(16'h000F, 16'h0000, 1'b1, lat, bcnt);
    check("cin_sum", sum, 16'h0010);

    // start held through RUN/DONE with changing operands
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("held_done", done, 1);
    check("held_sum", sum, 16'h3333);
    a = 16'h0102; b = 16'h0304; cin = 1'b0;
    @(negedge clk);
    if (done) dones++;
    check("held_single_done", dones, 1);
    @(negedge clk);
    start = 1'b0;
    check("held_restart_busy", busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("restart_latency", lat, 4);
    check("restart_sum", sum, 16'h0406);

    // Reset mid-RUN after two nibbles
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, lat, bcnt);
    check("post_rst_sum", sum, 16'h0002);
    check("post_rst_latency", lat, 4);

`ifdef ADDSUB_EN
    sub = 1'b1;
    do_op(16'h0005, 16'h0007, 1'b0, lat, bcnt);
    check("sub_sum", sum, 16'hFFFE);
    check("sub_cout", cout, 0);
    check("sub_ovf", ovf, 0);
    do_op(16'h8000, 16'h0001, 1'b0, lat, bcnt);
    check("sub_ovf_sum", sum, 16'h7FFF);
    check("sub_ovf_cout", cout, 1);
    check("sub_ovf_ovf", ovf, 1);
    sub = 1'b0;
`endif

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef ADDSUB_EN
      rs  = 1'($urandom);
      sub = rs;
`endif
      if (i < 4) begin
        ra = (i < 2) ? 16'h8000 : 16'h7FFF;
        rb = (i < 2) ? 16'h8000 : 16'h7FFF;
      end
      model(ra, rb, rc, rs, es, ec, eo);
      do_op(ra, rb, rc, lat, bcnt);
      check("rnd_sum", sum, es);
      check("rnd_cout", cout, ec);
      check("rnd_ovf", ovf, eo);
      check("rnd_latency", lat, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
